list_buffer_ctrl: RTL and testbench
===================================

# list_buffer_ctrl

Linked-list controller that shares one 40-entry x 73-bit two-port data memory among several logical FIFO queues. It owns the free-entry bitmap, per-entry next pointers, and per-queue head/tail/valid state. It drives the memory's write port on push and its asynchronous read port for the head of the queue selected by the pop index. It sits between the request side (push) and the consumer (pop), with the memory macro instantiated beside it by the parent.

## Interface
- QUEUES, 4: number of logical queues
- ENTRIES, 40: memory depth
- DATA_W, 73: payload width
- ADDR_W, 6: entry index width, $clog2(ENTRIES)
- QID_W, 2: queue index width, $clog2(QUEUES)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- push_valid  in  1  push request
- push_ready  out  1  at least one free entry
- push_index  in  QID_W  target queue
- push_data  in  DATA_W  payload
- valid  out  QUEUES  per-queue non-empty flags
- pop_valid  in  1  pop the head of queue pop_index
- pop_index  in  QID_W  queue whose head is presented and popped
- data_valid  out  1  valid[pop_index]
- data_bits  out  DATA_W  head payload of queue pop_index (mem_r_data)
- mem_w_en / mem_w_addr / mem_w_data  out  1/ADDR_W/DATA_W  memory write port
- mem_r_en / mem_r_addr  out  1/ADDR_W  memory read port
- mem_r_data  in  DATA_W  asynchronous read data

## Operation
- State:
  - used[ENTRIES] bitmap
  - next[ENTRIES] ADDR_W-wide pointers, not reset
  - head/tail[QUEUES] ADDR_W-wide pointers
  - valid[QUEUES] flags
- Free index free_idx = lowest-numbered clear bit of used. push_ready = |~used.
- Push fire (push_valid & push_ready):
  - mem_w_en=1, mem_w_addr=free_idx, mem_w_data=push_data; set used[free_idx].
  - If valid[q], write next[tail[q]]=free_idx.
  - If !valid[q], or the same queue is popped this cycle with head==tail, set head[q]=free_idx.
  - Set tail[q]=free_idx and valid[q]=1.
- Read: mem_r_en=valid[pop_index], mem_r_addr=head[pop_index]; data_bits=mem_r_data, combinational.
- Pop fire (pop_valid & valid[pop_index]):
  - Clear used[head[p]].
  - If head[p]==tail[p], clear valid[p] (unless a push to p fires the same cycle); otherwise head[p]=next[head[p]] (pre-update value).
- pop_valid with an empty queue is a protocol violation: no state change.
- An entry freed by pop is not allocatable until the next cycle, because free_idx uses pre-update used.
- Push and pop of different queues in the same cycle are independent.

## Timing
- Reset values: used=0, valid=0, head=tail=0. Outputs: push_ready=1, valid=0, data_valid=0, mem_w_en=0, mem_r_en=0.
- Push-to-visible latency is 1 cycle: valid[q] and data_bits update the cycle after push fire.
- Pop takes effect the same cycle; the new head is presented next cycle.
- Full (all used set): push_ready=0. A simultaneous pop frees an entry, and push_ready rises next cycle.
- Reset asserted mid-operation discards all queues on the next edge; memory contents are left untouched and are don't-care.

## Configuration
- LIST_BUFFER_ASSERT_EN defined: simulation assertions fire on:
  - pop_valid with valid[pop_index]=0
  - push_valid held while push_ready=0 and push_index changes
  - push_index or pop_index >= QUEUES
  - head==tail mismatch against a shadow per-queue occupancy counter
- Not defined: no assertions and no shadow counters; RTL is otherwise identical.

## Structure
- Package list_buffer_pkg: QUEUES, ENTRIES, DATA_W, derived ADDR_W/QID_W, typedefs entry_idx_t and queue_idx_t.
- Sub-module list_buffer_free_alloc: lowest-zero priority encoder over used, outputting free_idx and any_free.
- The data memory macro is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle: push_ready=1, valid=4'b0000, mem_w_en=0.
- Push 0xA, 0xB, 0xC to queue 2 on consecutive cycles: entries 0,1,2 written. Then pop queue 2 three times: data_bits=0xA,0xB,0xC; valid[2] falls after the third pop.
- Interleave: push q0=0x1, q1=0x2, q0=0x3. Pop q0 gives 0x1 then 0x3; pop q1 gives 0x2. Entries are reused lowest-first afterwards.
- Fill all 40 entries: push_ready=0 in the cycle after the 40th push. Pop one entry: push_ready=1 next cycle, and the next push reuses the freed index.
- Queue 3 holds one entry: push 0x55 and pop q3 in the same cycle. Next cycle valid[3]=1, head=tail=new index, data_bits=0x55.
- Assert reset with all queues non-empty: next cycle valid=0, push_ready=1. With LIST_BUFFER_ASSERT_EN defined, a pop of an empty queue raises an assertion.

Source files
------------

// File: rtl/list_buffer_pkg.sv
// Shared sizing and index types for the linked-list FIFO controller.
// The queue count, memory depth and payload width are set here.
package list_buffer_pkg;
    localparam int QUEUES  = 4;
    localparam int ENTRIES = 40;
    localparam int DATA_W  = 73;
    localparam int ADDR_W  = $clog2(ENTRIES);
    localparam int QID_W   = $clog2(QUEUES);

    typedef logic [ADDR_W-1:0] entry_idx_t;
    typedef logic [QID_W-1:0]  queue_idx_t;
endpackage

// File: rtl/list_buffer_free_alloc.sv
// Free-entry allocator: picks the lowest-numbered entry whose used bit is clear.
import list_buffer_pkg::*;

module list_buffer_free_alloc (
    input  logic [ENTRIES-1:0] used,
    output logic [ADDR_W-1:0]  free_idx,
    output logic               any_free
);
    // Scan from the top down so the lowest clear bit is the last one to win.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!used[i]) begin
                free_idx = ADDR_W'(i);
            end
        end
    end

    assign any_free = ~&used;
endmodule

// File: rtl/list_buffer_ctrl.sv
// Linked-list controller sharing one external memory among QUEUES logical FIFOs.
// Define LIST_BUFFER_ASSERT_EN to enable protocol and consistency assertions.
import list_buffer_pkg::*;

module list_buffer_ctrl (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [QID_W-1:0]  push_index,
    input  logic [DATA_W-1:0] push_data,
    output logic [QUEUES-1:0] valid,
    input  logic              pop_valid,
    input  logic [QID_W-1:0]  pop_index,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_bits,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [DATA_W-1:0] mem_r_data
);
    logic [ENTRIES-1:0] used_reg;
    logic [ENTRIES-1:0] used_next;
    entry_idx_t         next_reg [ENTRIES];
    entry_idx_t         head_reg [QUEUES];
    entry_idx_t         tail_reg [QUEUES];
    entry_idx_t         head_next [QUEUES];
    entry_idx_t         tail_next [QUEUES];
    logic [QUEUES-1:0]  valid_reg;
    logic [QUEUES-1:0]  valid_next;
    logic [QUEUES-1:0]  push_q;
    logic [QUEUES-1:0]  pop_q;
    logic [QUEUES-1:0]  last_q;

    entry_idx_t free_idx;
    logic       any_free;
    logic       push_fire;
    logic       pop_fire;
    entry_idx_t pop_head;

    list_buffer_free_alloc u_free_alloc (
        .used     (used_reg),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign push_fire = push_valid & any_free;
    assign pop_fire  = pop_valid & valid_reg[pop_index];
    assign pop_head  = head_reg[pop_index];

    // Allocation and release never target the same entry: one is clear, the other set.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_used
            assign used_next[gi] = (push_fire && (free_idx == ADDR_W'(gi))) ? 1'b1 :
                                   (pop_fire && (pop_head == ADDR_W'(gi)))  ? 1'b0 :
                                   used_reg[gi];
        end

        for (gi = 0; gi < QUEUES; gi++) begin : g_queue
            assign push_q[gi] = push_fire && (push_index == QID_W'(gi));
            assign pop_q[gi]  = pop_fire && (pop_index == QID_W'(gi));
            assign last_q[gi] = (head_reg[gi] == tail_reg[gi]);

            // A push into an empty queue, or one emptied by a same-cycle pop, becomes the head.
            assign head_next[gi] =
                (push_q[gi] && (!valid_reg[gi] || (pop_q[gi] && last_q[gi]))) ? free_idx :
                (pop_q[gi] && !last_q[gi]) ? next_reg[head_reg[gi]] :
                head_reg[gi];
            assign tail_next[gi]  = push_q[gi] ? free_idx : tail_reg[gi];
            assign valid_next[gi] = push_q[gi] | (valid_reg[gi] & ~(pop_q[gi] & last_q[gi]));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            used_reg  <= '0;
            valid_reg <= '0;
            for (int i = 0; i < QUEUES; i++) begin
                head_reg[i] <= '0;
                tail_reg[i] <= '0;
            end
        end else begin
            used_reg  <= used_next;
            valid_reg <= valid_next;
            for (int i = 0; i < QUEUES; i++) begin
                head_reg[i] <= head_next[i];
                tail_reg[i] <= tail_next[i];
            end
        end
    end

    // Link pointers are only ever read behind a valid head, so they need no reset.
    always_ff @(posedge clock) begin
        if (push_fire && valid_reg[push_index]) begin
            next_reg[tail_reg[push_index]] <= free_idx;
        end
    end

    assign push_ready = any_free;
    assign valid      = valid_reg;
    assign mem_w_en   = push_fire;
    assign mem_w_addr = free_idx;
    assign mem_w_data = push_data;
    assign mem_r_en   = valid_reg[pop_index];
    assign mem_r_addr = pop_head;
    assign data_valid = valid_reg[pop_index];
    assign data_bits  = mem_r_data;

`ifdef LIST_BUFFER_ASSERT_EN
    logic [ADDR_W:0] count_reg [QUEUES];
    logic            push_valid_prev_reg;
    logic            push_ready_prev_reg;
    queue_idx_t      push_index_prev_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            push_valid_prev_reg <= 1'b0;
            push_ready_prev_reg <= 1'b1;
            push_index_prev_reg <= '0;
            for (int i = 0; i < QUEUES; i++) begin
                count_reg[i] <= '0;
            end
        end else begin
            push_valid_prev_reg <= push_valid;
            push_ready_prev_reg <= push_ready;
            push_index_prev_reg <= push_index;
            for (int i = 0; i < QUEUES; i++) begin
                count_reg[i] <= count_reg[i] + (ADDR_W+1)'(push_q[i]) - (ADDR_W+1)'(pop_q[i]);
            end

            a_pop_empty: assert (!(pop_valid && !valid_reg[pop_index]))
                else $error("list_buffer_ctrl: pop of empty queue %0d", pop_index);
            a_push_hold: assert (!(push_valid_prev_reg && !push_ready_prev_reg && push_valid &&
                                   (push_index != push_index_prev_reg)))
                else $error("list_buffer_ctrl: push_index changed while stalled");
            a_index: assert ((int'(push_index) < QUEUES) && (int'(pop_index) < QUEUES))
                else $error("list_buffer_ctrl: queue index out of range");
            for (int i = 0; i < QUEUES; i++) begin
                if (valid_reg[i]) begin
                    a_occupancy: assert ((head_reg[i] == tail_reg[i]) == (count_reg[i] == 1))
                        else $error("list_buffer_ctrl: queue %0d head/tail vs count %0d", i, count_reg[i]);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_list_buffer_ctrl.sv
// Directed bench for list_buffer_ctrl with a behavioural memory and a per-queue scoreboard.
module tb_list_buffer_ctrl;
    import list_buffer_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              push_valid = 1'b0;
    logic              push_ready;
    logic [QID_W-1:0]  push_index = '0;
    logic [DATA_W-1:0] push_data = '0;
    logic [QUEUES-1:0] valid;
    logic              pop_valid = 1'b0;
    logic [QID_W-1:0]  pop_index = '0;
    logic              data_valid;
    logic [DATA_W-1:0] data_bits;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_r_data;

    always #5 clock = ~clock;

    list_buffer_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_index (push_index),
        .push_data  (push_data),
        .valid      (valid),
        .pop_valid  (pop_valid),
        .pop_index  (pop_index),
        .data_valid (data_valid),
        .data_bits  (data_bits),
        .mem_w_en   (mem_w_en),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_en   (mem_r_en),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    logic [DATA_W-1:0] mem [ENTRIES];
    always @(posedge clock) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    end
    assign mem_r_data = mem[mem_r_addr];

    // Scoreboard: expected payloads and the entries the model believes hold them.
    logic [DATA_W-1:0] exp_q [QUEUES][$];
    int                idx_q [QUEUES][$];
    logic [ENTRIES-1:0] m_used = '0;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free();
        for (int i = 0; i < ENTRIES; i++) begin
            if (!m_used[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic pv, input int pi, input logic [DATA_W-1:0] pd,
                        input logic ov, input int oi);
        int f;
        int freed;
        logic [QUEUES-1:0] mv;
        logic fire_push;
        logic fire_pop;
        @(negedge clock);
        push_valid = pv;
        push_index = QID_W'(pi);
        push_data  = pd;
        pop_valid  = ov;
        pop_index  = QID_W'(oi);
        #1;
        f = m_free();
        for (int q = 0; q < QUEUES; q++) mv[q] = (exp_q[q].size() != 0);
        fire_push = pv && (f >= 0);
        fire_pop  = ov && mv[oi];
        chk("push_ready", push_ready, (f >= 0));
        chk("valid", valid, mv);
        chk("mem_w_en", mem_w_en, fire_push);
        if (fire_push) begin
            chk("mem_w_addr", mem_w_addr, f);
            chk("mem_w_data", mem_w_data, pd);
        end
        chk("data_valid", data_valid, mv[oi]);
        chk("mem_r_en", mem_r_en, mv[oi]);
        if (mv[oi]) chk("data_bits", data_bits, exp_q[oi][0]);
        @(posedge clock);
        if (fire_pop) begin
            freed = idx_q[oi].pop_front();
            void'(exp_q[oi].pop_front());
            m_used[freed] = 1'b0;
        end
        if (fire_push) begin
            m_used[f] = 1'b1;
            exp_q[pi].push_back(pd);
            idx_q[pi].push_back(f);
        end
        $display("[TB] t=%0t push=%0b q%0d d=%0h fire=%0b | pop=%0b q%0d fire=%0b",
                 $time, pv, pi, pd, fire_push, ov, oi, fire_pop);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        @(posedge clock);
        for (int q = 0; q < QUEUES; q++) begin
            exp_q[q].delete();
            idx_q[q].delete();
        end
        m_used = '0;
        @(negedge clock);
        reset = 1'b0;
        $display("[TB] t=%0t reset", $time);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        do_reset();
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 2);

        // Three pushes to queue 2, then three pops.
        step(1, 2, 73'hA, 0, 2);
        step(1, 2, 73'hB, 0, 2);
        step(1, 2, 73'hC, 0, 2);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 2);
        step(0, 0, '0, 0, 2);

        // Interleaved queues, with a push and a pop of different queues together.
        step(1, 0, 73'h1, 0, 0);
        step(1, 1, 73'h2, 0, 0);
        step(1, 0, 73'h3, 1, 0);
        step(0, 0, '0, 1, 0);
        step(1, 3, 73'h7, 1, 1);
        step(0, 0, '0, 1, 3);

        // Fill every entry, stall, then free one with a pop.
        for (int i = 0; i < ENTRIES; i++) step(1, i % QUEUES, rnd_data(), 0, 0);
        step(1, 1, 73'h99, 0, 1);
        step(1, 1, 73'h99, 1, 1);
        step(1, 1, 73'h99, 0, 1);
        step(0, 0, '0, 0, 1);
        for (int q = 0; q < QUEUES; q++) begin
            for (int n = 0; n < ENTRIES && exp_q[q].size() != 0; n++) step(0, 0, '0, 1, q);
        end
        step(0, 0, '0, 0, 0);

        // Single-entry queue 3: push and pop in the same cycle.
        step(1, 3, 73'h44, 0, 3);
        step(1, 3, 73'h55, 1, 3);
        step(0, 0, '0, 0, 3);
        step(0, 0, '0, 1, 3);
        step(0, 0, '0, 0, 3);

        // Reset with every queue non-empty.
        for (int q = 0; q < QUEUES; q++) step(1, q, rnd_data(), 0, 0);
        step(0, 0, '0, 0, 1);
        do_reset();
        step(0, 0, '0, 0, 0);
        step(1, 2, 73'h123, 0, 2);
        step(0, 0, '0, 1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
